// File: rtl/backend_seq_ctrl_pkg.sv
// Shared definitions for the sensor front-end power-up sequencer.
// Holds the sequencer state encoding, frame layout and state-group helpers.
package backend_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CFG    = 3'd1,
        ST_EN_RO  = 3'd2,
        ST_WAIT1  = 3'd3,
        ST_IB_SET = 3'd4,
        ST_RESETS = 3'd5,
        ST_WAIT2  = 3'd6,
        ST_READY  = 3'd7
    } seq_state_t;

    // Even-parity bit sits at the LSB of every configuration frame.
    localparam int PARITY_POS = 0;

    function automatic logic seq_active(seq_state_t s);
        return !(s inside {ST_IDLE, ST_CFG});
    endfunction

    function automatic logic seq_released(seq_state_t s);
        return s inside {ST_RESETS, ST_WAIT2, ST_READY};
    endfunction

endpackage

// File: rtl/backend_mavg.sv
// Moving average of the ADC samples over a circular buffer of 2**AVG_LOG2 entries.
// Input is registered first, so a sample reaches avg two clocks after it is taken.
module backend_mavg #(
    parameter int ADC_W    = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] avg
);

    localparam int DEPTH = 2 ** AVG_LOG2;
    localparam int SUM_W = ADC_W + AVG_LOG2;

    logic [ADC_W-1:0]    sample_q;
    logic [ADC_W-1:0]    buf_mem [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [SUM_W-1:0]    sum;

    // The running sum can never exceed DEPTH * max sample, so SUM_W bits never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            wr_ptr   <= '0;
            sum      <= '0;
            avg      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            sample_q        <= sample;
            buf_mem[wr_ptr] <= sample_q;
            sum             <= sum + SUM_W'(sample_q) - SUM_W'(buf_mem[wr_ptr]);
            wr_ptr          <= wr_ptr + 1'b1;
            avg             <= ADC_W'(sum >> AVG_LOG2);
        end
    end

endmodule

// File: rtl/backend_seq_ctrl.sv
// Power-up sequencer and bias controller for the sensor analog front-end.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | one cycle after reset
//  CFG       | waiting for the first parity-clean configuration frame
//  EN_RO     | ring oscillator enabled
//  WAIT1     | oscillator settle, WAIT_CYC cycles
//  IB_SET    | bias picked from the current average
//  RESETS    | amplifier and core released from reset
//  WAIT2     | front-end settle, WAIT_CYC cycles
//  READY     | terminal; bias tracks the average with hysteresis
module backend_seq_ctrl
    import backend_seq_ctrl_pkg::*;
#(
    parameter int ADC_W    = 4,
    parameter int AVG_LOG2 = 2,
    parameter int SER_W    = 8,
    parameter int GAIN_W   = 3,
    parameter int WAIT_CYC = 5,
    parameter int HI_TH    = 12,
    parameter int LO_TH    = 8,
    parameter int DIV_LOG2 = 2
) (
    input  logic              i_clk,
    input  logic              i_resetbALL,
    input  logic              i_sclk,
    input  logic              i_sdin,
    input  logic              i_restart,
    input  logic [ADC_W-1:0]  i_ADCout,
    output logic [GAIN_W-1:0] o_gain,
    output logic              o_cfg_err,
    output logic              o_enableRO,
    output logic              o_resetb_amp,
    output logic              o_resetb_core,
    output logic              o_Ibias_2x,
    output logic [ADC_W-1:0]  o_avg,
    output logic              o_ready,
    output logic              o_core_clk
);

    localparam int CNT_W  = $clog2(SER_W + 1);
    localparam int WAIT_W = $clog2(WAIT_CYC + 1);
    localparam logic [ADC_W-1:0] HI_LVL = ADC_W'(HI_TH);
    localparam logic [ADC_W-1:0] LO_LVL = ADC_W'(LO_TH);

    logic             sclk_s1, sclk_s2, sclk_d;
    logic             sdin_s1, sdin_s2;
    logic             sclk_rise;
    logic [SER_W-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             frame_vld;
    logic             parity_calc;
    logic             frame_ok;
    logic             frame_bad;

    seq_state_t          state;
    seq_state_t          nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DIV_LOG2-1:0] div;

    assign sclk_rise = sclk_s2 & ~sclk_d;

    // A frame is flagged on the edge its last bit lands; it is judged one cycle later.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_d    <= 1'b0;
            sdin_s1   <= 1'b0;
            sdin_s2   <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_vld <= 1'b0;
        end else begin
            sclk_s1   <= i_sclk;
            sclk_s2   <= sclk_s1;
            sclk_d    <= sclk_s2;
            sdin_s1   <= i_sdin;
            sdin_s2   <= sdin_s1;
            frame_vld <= 1'b0;
            if (sclk_rise) begin
                shreg <= {shreg[SER_W-2:0], sdin_s2};
                if (bit_cnt == CNT_W'(SER_W - 1)) begin
                    bit_cnt   <= '0;
                    frame_vld <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign parity_calc = ^shreg[SER_W-1:PARITY_POS+1];
    assign frame_ok    = frame_vld & (parity_calc == shreg[PARITY_POS]);
    assign frame_bad   = frame_vld & (parity_calc != shreg[PARITY_POS]);

    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            o_gain    <= '0;
            o_cfg_err <= 1'b0;
        end else begin
            o_cfg_err <= frame_bad;
            if (frame_ok) begin
                o_gain <= shreg[SER_W-1 -: GAIN_W];
            end
        end
    end

    backend_mavg #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_mavg (
        .clk    (i_clk),
        .rst_n  (i_resetbALL),
        .sample (i_ADCout),
        .avg    (o_avg)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   nxt = ST_CFG;
            ST_CFG:    if (frame_ok) nxt = ST_EN_RO;
            ST_EN_RO:  nxt = ST_WAIT1;
            ST_WAIT1:  if (wait_cnt == '0) nxt = ST_IB_SET;
            ST_IB_SET: nxt = ST_RESETS;
            ST_RESETS: nxt = ST_WAIT2;
            ST_WAIT2:  if (wait_cnt == '0) nxt = ST_READY;
            ST_READY:  nxt = ST_READY;
            default:   nxt = ST_IDLE;
        endcase
        if (i_restart && seq_active(state)) begin
            nxt = ST_EN_RO;
        end
    end

    // Outputs are decoded from nxt so they switch on the same edge as the state.
    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            o_enableRO    <= 1'b0;
            o_resetb_amp  <= 1'b0;
            o_resetb_core <= 1'b0;
            o_ready       <= 1'b0;
            o_Ibias_2x    <= 1'b0;
        end else begin
            state         <= nxt;
            o_enableRO    <= seq_active(nxt);
            o_resetb_amp  <= seq_released(nxt);
            o_resetb_core <= seq_released(nxt);
            o_ready       <= (nxt == ST_READY);

            case (nxt)
                ST_WAIT1, ST_WAIT2: begin
                    if (state != nxt) begin
                        wait_cnt <= WAIT_W'(WAIT_CYC - 1);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: wait_cnt <= '0;
            endcase

            if (nxt == ST_IB_SET) begin
                o_Ibias_2x <= (o_avg > HI_LVL);
            end else if (nxt == ST_READY) begin
                if (o_avg < LO_LVL) begin
                    o_Ibias_2x <= 1'b0;
                end else if (o_avg > HI_LVL) begin
                    o_Ibias_2x <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetbALL) begin
        if (!i_resetbALL) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // 1x bias passes the system clock straight through once the core is out of reset.
    assign o_core_clk = o_Ibias_2x ? div[DIV_LOG2-1] : (seq_released(state) & i_clk);

endmodule

// File: tb/tb_backend_seq_ctrl.sv
// Bench for backend_seq_ctrl: directed bring-up scenario then randomized traffic.
// Outputs are compared every cycle against a sequence-position model of the controller.
module tb_backend_seq_ctrl;

    localparam int ADC_W     = 4;
    localparam int SER_W     = 8;
    localparam int GAIN_W    = 3;
    localparam int WAIT_CYC  = 5;
    localparam int HI_TH     = 12;
    localparam int LO_TH     = 8;
    localparam int DIV_LOG2  = 2;
    localparam int POS_IBSET = WAIT_CYC + 1;
    localparam int POS_RESET = WAIT_CYC + 2;
    localparam int POS_READY = 2 * WAIT_CYC + 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              sclk = 1'b0;
    logic              sdin = 1'b0;
    logic              restart = 1'b0;
    logic [ADC_W-1:0]  adc = '0;
    logic [GAIN_W-1:0] gain;
    logic              cfg_err;
    logic              enable_ro;
    logic              resetb_amp;
    logic              resetb_core;
    logic              ibias_2x;
    logic [ADC_W-1:0]  avg;
    logic              ready;
    logic              core_clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    backend_seq_ctrl dut (
        .i_clk         (clk),
        .i_resetbALL   (rst_n),
        .i_sclk        (sclk),
        .i_sdin        (sdin),
        .i_restart     (restart),
        .i_ADCout      (adc),
        .o_gain        (gain),
        .o_cfg_err     (cfg_err),
        .o_enableRO    (enable_ro),
        .o_resetb_amp  (resetb_amp),
        .o_resetb_core (resetb_core),
        .o_Ibias_2x    (ibias_2x),
        .o_avg         (avg),
        .o_ready       (ready),
        .o_core_clk    (core_clk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 waiting for config, 2 running; pos = cycles since oscillator enable.
    int         m_mode, m_pos, m_gain, m_err, m_ibias, m_avg, m_n, m_nbits;
    bit         m_pending;
    logic [7:0] m_frame, m_bits;
    bit         sck_h [1:3];
    bit         sdi_h [1:3];
    int         adc_h [0:5];

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_gain = 0; m_err = 0; m_ibias = 0; m_avg = 0;
        m_n = 0; m_nbits = 0; m_pending = 0; m_frame = '0; m_bits = '0;
        for (int k = 1; k <= 3; k++) begin
            sck_h[k] = 0;
            sdi_h[k] = 0;
        end
        for (int k = 0; k <= 5; k++) adc_h[k] = 0;
    endtask

    task automatic model_step();
        int old_avg;
        bit rise, dbit, ok_evt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        old_avg = m_avg;
        rise    = sck_h[2] && !sck_h[3];
        dbit    = sdi_h[2];
        ok_evt  = 0;
        m_err   = 0;
        if (m_pending) begin
            if ($countones(m_frame) % 2 == 0) begin
                m_gain = int'(m_frame[7:5]);
                ok_evt = 1;
            end else begin
                m_err = 1;
            end
        end
        m_pending = 0;
        if (rise) begin
            m_bits = {m_bits[6:0], dbit};
            m_nbits++;
            if (m_nbits == SER_W) begin
                m_pending = 1;
                m_frame   = m_bits;
                m_nbits   = 0;
            end
        end
        sck_h[3] = sck_h[2]; sck_h[2] = sck_h[1]; sck_h[1] = sclk;
        sdi_h[3] = sdi_h[2]; sdi_h[2] = sdi_h[1]; sdi_h[1] = sdin;

        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (ok_evt) begin
                m_mode = 2;
                m_pos  = 0;
            end
        end else if (restart) begin
            m_pos = 0;
        end else if (m_pos < POS_READY) begin
            m_pos++;
        end

        if (m_mode == 2 && m_pos == POS_IBSET) begin
            m_ibias = (old_avg > HI_TH) ? 1 : 0;
        end else if (m_mode == 2 && m_pos == POS_READY) begin
            if (old_avg < LO_TH) m_ibias = 0;
            else if (old_avg > HI_TH) m_ibias = 1;
        end

        for (int k = 5; k >= 1; k--) adc_h[k] = adc_h[k-1];
        adc_h[0] = int'(adc);
        m_avg = (adc_h[2] + adc_h[3] + adc_h[4] + adc_h[5]) / 4;
        m_n++;
    endtask

    task automatic compare_all();
        int e_en, e_rb, e_rdy, e_cc;
        e_en  = (m_mode == 2) ? 1 : 0;
        e_rb  = (m_mode == 2 && m_pos >= POS_RESET) ? 1 : 0;
        e_rdy = (m_mode == 2 && m_pos == POS_READY) ? 1 : 0;
        e_cc  = (m_ibias != 0) ? ((m_n >> (DIV_LOG2 - 1)) & 1) : e_rb;
        chk("m_gain", int'(gain), m_gain);
        chk("m_cfg_err", int'(cfg_err), m_err);
        chk("m_enable_ro", int'(enable_ro), e_en);
        chk("m_resetb_amp", int'(resetb_amp), e_rb);
        chk("m_resetb_core", int'(resetb_core), e_rb);
        chk("m_ready", int'(ready), e_rdy);
        chk("m_ibias", int'(ibias_2x), m_ibias);
        chk("m_avg", int'(avg), m_avg);
        chk("m_core_clk", int'(core_clk), e_cc);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (chk_en) compare_all();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] f, input int h);
        for (int b = 7; b >= 0; b--) begin
            @(negedge clk);
            sclk = 1'b0;
            sdin = f[b];
            repeat (h - 1) @(negedge clk);
            @(negedge clk);
            sclk = 1'b1;
            repeat (h - 1) @(negedge clk);
        end
        @(negedge clk);
        sclk = 1'b0;
    endtask

    initial begin
        int n, seen, bad, ones;
        bit cs [8];
        logic [6:0] d7;
        logic [7:0] fr;

        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_gain", int'(gain), 0);
        chk("rst_outs", int'({enable_ro, resetb_amp, resetb_core, ready, ibias_2x, cfg_err}), 0);

        // bad parity frame: one error pulse, config unchanged
        send_frame(8'b1010_0001, 2);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (cfg_err) seen++;
        end
        chk("bad_err_pulse", seen, 1);
        chk("bad_gain_hold", int'(gain), 0);
        chk("bad_stay_cfg", int'(enable_ro), 0);

        @(negedge clk);
        adc = 4'd14;
        send_frame(8'b1010_0000, 2);
        n = 0;
        while (gain != 3'd5 && n < 12) begin
            step();
            n++;
        end
        chk("good_gain", int'(gain), 5);
        chk("good_en_ro", int'(enable_ro), 1);
        chk("good_no_err", int'(cfg_err), 0);

        n = 0;
        while (!resetb_amp && n < 20) begin
            step();
            n++;
        end
        chk("pre_reset_len", n, 7);
        chk("ibias_at_resets", int'(ibias_2x), 1);
        n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        chk("wait2_len", n, 6);
        chk("ready_core_rb", int'(resetb_core), 1);

        for (int i = 0; i < 8; i++) begin
            cs[i] = core_clk;
            step();
        end
        bad = 0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            if (cs[i] != cs[i+4] || cs[i] == cs[i+2]) bad++;
            ones += int'(cs[i]);
        end
        chk("core_div4_shape", bad, 0);
        chk("core_div4_duty", ones, 2);

        // hysteresis sweep 14 -> 10 -> 6 -> 10
        @(negedge clk);
        adc = 4'd10;
        step(); chk("lag_edge0", int'(avg), 14);
        step(); chk("lag_edge1", int'(avg), 14);
        step(); chk("lag_edge2", int'(avg), 13);
        repeat (6) step();
        chk("sweep10_avg", int'(avg), 10);
        chk("sweep10_bias", int'(ibias_2x), 1);
        @(negedge clk);
        adc = 4'd6;
        repeat (8) step();
        chk("sweep6_avg", int'(avg), 6);
        chk("sweep6_bias", int'(ibias_2x), 0);
        @(negedge clk);
        adc = 4'd10;
        repeat (8) step();
        chk("sweep10b_avg", int'(avg), 10);
        chk("sweep10b_bias", int'(ibias_2x), 0);

        @(negedge clk);
        restart = 1'b1;
        step();
        chk("rs_ready", int'(ready), 0);
        chk("rs_resetb", int'({resetb_amp, resetb_core}), 0);
        chk("rs_en_ro", int'(enable_ro), 1);
        chk("rs_gain", int'(gain), 5);
        @(negedge clk);
        restart = 1'b0;
        n = 0;
        while (!resetb_amp && n < 20) begin
            step();
            n++;
        end
        chk("replay_resetb", int'(resetb_amp), 1);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", int'({gain, cfg_err, enable_ro, resetb_amp, resetb_core,
                                   ibias_2x, avg, ready, core_clk}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();
        chk("post_rst_cfg", int'(enable_ro), 0);
        chk("post_rst_gain", int'(gain), 0);

        for (int it = 0; it < 40; it++) begin
            int act, lo, hi, len;
            act = $urandom_range(0, 9);
            if (act < 3) begin
                d7 = 7'($urandom);
                fr = {d7, ^d7};
                if ($urandom_range(0, 3) == 0) fr[0] = ~fr[0];
                send_frame(fr, $urandom_range(1, 3));
            end else if (act < 9) begin
                case ($urandom_range(0, 3))
                    0: begin lo = 0;  hi = 7;  end
                    1: begin lo = 8;  hi = 12; end
                    2: begin lo = 13; hi = 15; end
                    default: begin lo = 0; hi = 15; end
                endcase
                len = $urandom_range(10, 40);
                for (int c = 0; c < len; c++) begin
                    @(negedge clk);
                    adc = ADC_W'($urandom_range(lo, hi));
                    restart = ($urandom_range(0, 15) == 0);
                end
                @(negedge clk);
                restart = 1'b0;
            end else begin
                @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
